// File: rtl/mc_mem_responder_if.sv
// ---------------------------------------------------------------------------
// mc_mem_responder_if
// Memory port between the multicycle MIPS control path (master) and the
// unified instruction/data memory responder (slave).
//   req        master->slave  request strobe, sampled by the slave when idle
//   mem_we     master->slave  1 = store, 0 = fetch/load
//   mem_addr   master->slave  byte address
//   mem_wdata  master->slave  store data
//   mem_rdata  slave->master  read data, valid with mem_ready on a read
//   mem_ready  slave->master  one-cycle completion pulse
//   mem_err    slave->master  qualifies mem_ready: misaligned or out of range
//   mem_busy   slave->master  responder is servicing a request
// ---------------------------------------------------------------------------
interface mc_mem_responder_if;
    logic        req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;
    logic        mem_busy;

    modport master (
        output req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err, mem_busy
    );

    modport slave (
        input  req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err, mem_busy
    );
endinterface

// File: rtl/mc_mem_responder.sv
// ---------------------------------------------------------------------------
// mc_mem_responder
// Word-addressed unified instruction/data memory for the multicycle MIPS
// datapath. Accepts one request at a time, inserts WAIT_STATES wait cycles,
// performs the access and answers with a one-cycle mem_ready pulse carrying
// read data or an error flag. All outputs are registered.
// Ports:
//   clock  in   rising-edge clock
//   rst    in   synchronous, active-high reset (array contents are kept)
//   bus    slave modport of mc_mem_responder_if (request/response signals)
// ---------------------------------------------------------------------------
module mc_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic               clock,
    input  logic               rst,
    mc_mem_responder_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        mem_wr;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] idx;
    logic              acc_err;

    assign idx = addr_q[ADDR_W+1:2];
    // Any set bit above the word index means the word lies beyond the array.
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready_d = 1'b0;
        mem_wr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    we_d    = bus.mem_we;
                    wcnt_d  = WAIT_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    // Access edge: result and the ready pulse register together
                    // so the DONE cycle presents them with no input-to-output path.
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    if (acc_err) begin
                        err_d = 1'b1;
                    end else if (we_q) begin
                        mem_wr = 1'b1;
                        err_d  = 1'b0;
                    end else begin
                        rdata_d = mem_q[idx];
                        err_d   = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Latched request fields are pure data and need no reset.
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
    end

    // Array has no reset; reset on the access edge cancels the store.
    always_ff @(posedge clock) begin
        if (mem_wr && !rst) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_busy  = busy_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
module tb_mc_mem_responder;
    logic clock;
    logic rst;
    logic rst3;
    int   checks;
    int   errors;

    mc_mem_responder_if bus ();
    mc_mem_responder_if bus3 ();

    mc_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    mc_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
        .clock (clock),
        .rst   (rst3),
        .bus   (bus3.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            bus3.req = r; bus3.mem_we = we; bus3.mem_addr = a; bus3.mem_wdata = wd;
        end else begin
            bus.req = r; bus.mem_we = we; bus.mem_addr = a; bus.mem_wdata = wd;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus3.mem_ready : bus.mem_ready;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? bus3.mem_busy : bus.mem_busy;
    endfunction

    // One transaction: returns edges from the sampling edge to ready, and the
    // response captured in the ready cycle; then checks the pulse is one wide.
    task automatic access(input bit sel, input string tag, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        drive(sel, 1'b1, we, a, wd);
        step();
        drive(sel, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
        lat = 0;
        while (!rdy(sel) && lat < 20) begin
            step();
            lat++;
        end
        rd = sel ? bus3.mem_rdata : bus.mem_rdata;
        er = sel ? bus3.mem_err : bus.mem_err;
        step();
        check({tag, "_ready_width"}, 32'(rdy(sel)), 32'd0);
        check({tag, "_busy_after"}, 32'(bsy(sel)), 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          rt[3];
    logic [31:0] rdv[3];
    int          n;
    int          lows;
    int          seen;

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        rst3 = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with req held high
        step();
        step();
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_busy", 32'(bus.mem_busy), 32'd0);
        check("rst_err", 32'(bus.mem_err), 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        rst  = 1'b0;
        rst3 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("rst_no_txn_busy", 32'(bus.mem_busy), 32'd0);
        check("rst_no_txn_ready", 32'(bus.mem_ready), 32'd0);

        // Store / load round trip
        access(1'b0, "st10", 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        check("st10_lat", 32'(lat), 32'd3);
        check("st10_err", 32'(er), 32'd0);
        check("st10_rdata_unchanged", rd, 32'd0);
        access(1'b0, "ld10", 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("ld10_lat", 32'(lat), 32'd3);
        check("ld10_rdata", rd, 32'hDEAD_BEEF);
        check("ld10_err", 32'(er), 32'd0);
        check("ld10_rdata_hold", bus.mem_rdata, 32'hDEAD_BEEF);

        // Misaligned store leaves the word untouched
        access(1'b0, "st13", 1'b1, 32'h13, 32'h1234_5678, lat, rd, er);
        check("st13_err", 32'(er), 32'd1);
        check("st13_rdata_unchanged", rd, 32'hDEAD_BEEF);
        check("st13_err_hold", 32'(bus.mem_err), 32'd1);
        access(1'b0, "ld10b", 1'b0, 32'h10, 32'h0, lat, rd, er);
        check("ld10b_rdata", rd, 32'hDEAD_BEEF);
        check("ld10b_err", 32'(er), 32'd0);

        // Out of range, with the last word as the in-range boundary
        access(1'b0, "st3fc", 1'b1, 32'h3FC, 32'h0BAD_F00D, lat, rd, er);
        check("st3fc_err", 32'(er), 32'd0);
        access(1'b0, "ld400", 1'b0, 32'h400, 32'h0, lat, rd, er);
        check("ld400_err", 32'(er), 32'd1);
        check("ld400_rdata_hold", rd, 32'hDEAD_BEEF);
        access(1'b0, "ld3fc", 1'b0, 32'h3FC, 32'h0, lat, rd, er);
        check("ld3fc_err", 32'(er), 32'd0);
        check("ld3fc_rdata", rd, 32'h0BAD_F00D);

        // Held req with address changes during WAIT
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        bus.mem_addr = 32'h3FC;
        n = 0;
        lows = 0;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 5) bus.mem_addr = 32'h10;
            if (bus.mem_ready && n < 3) begin
                rt[n]  = i;
                rdv[n] = bus.mem_rdata;
                n++;
            end
            if (!bus.mem_busy) lows++;
        end
        bus.req = 1'b0;
        check("held_pulses", 32'(n), 32'd3);
        check("held_t0", 32'(rt[0]), 32'd3);
        check("held_t1", 32'(rt[1]), 32'd8);
        check("held_t2", 32'(rt[2]), 32'd13);
        check("held_d0", rdv[0], 32'hDEAD_BEEF);
        check("held_d1", rdv[1], 32'h0BAD_F00D);
        check("held_d2", rdv[2], 32'hDEAD_BEEF);
        check("held_busy_lows", 32'(lows), 32'd2);
        step();
        check("held_end_busy", 32'(bus.mem_busy), 32'd0);

        // Reset during WAIT cancels the store (3 wait states)
        access(1'b1, "w3_st20", 1'b1, 32'h20, 32'h1111_1111, lat, rd, er);
        check("w3_st20_lat", 32'(lat), 32'd4);
        access(1'b1, "w3_ld20", 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("w3_ld20_rdata", rd, 32'h1111_1111);
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("w3_mid_busy", 32'(bus3.mem_busy), 32'd1);
        rst3 = 1'b1;
        step();
        rst3 = 1'b0;
        check("w3_rst_busy", 32'(bus3.mem_busy), 32'd0);
        check("w3_rst_rdata", bus3.mem_rdata, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus3.mem_ready) seen++;
        end
        check("w3_no_ready", 32'(seen), 32'd0);
        access(1'b1, "w3_ld20b", 1'b0, 32'h20, 32'h0, lat, rd, er);
        check("w3_ld20b_rdata", rd, 32'h1111_1111);
        check("w3_ld20b_err", 32'(er), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
